// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - data memory access modes and arbiter FSM encodings
package dm_arb_pkg;

   localparam logic [2:0] DM_NONE = 3'd0;
   localparam logic [2:0] DM_W    = 3'd1;
   localparam logic [2:0] DM_H    = 3'd2;
   localparam logic [2:0] DM_HU   = 3'd3;
   localparam logic [2:0] DM_B    = 3'd4;
   localparam logic [2:0] DM_BU   = 3'd5;

   localparam logic DM_WRITE_ENABLED = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  mode;
   } dm_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin selector with one-hot grant
module rr_arb2 (
   input  logic       req0,
   input  logic       req1,
   input  logic       ptr,
   input  logic       en,
   output logic [1:0] gnt
);

   // ptr names the port served last; on a tie the other port wins
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req0 && req1) begin
            gnt = ptr ? 2'b01 : 2'b10;
         end else begin
            gnt = {req1, req0};
         end
      end
   end

endmodule

// File: rtl/dm_arb.sv
// rtl/dm_arb.sv - two-port arbiter in front of a single data memory
module dm_arb
   import dm_arb_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic [2:0]  mode0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   input  logic [2:0]  mode1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic        dm_we,
   output logic [2:0]  dm_mode,
   input  logic [31:0] dm_rdata,
   input  logic        dm_invalid,
   output logic [15:0] err_count
);

   arb_state_t  state_q, state_d;
   logic        last_q;
   logic        sel_q;
   dm_req_t     pay_q;
   logic [31:0] rdata_cap_q;
   logic        inv_cap_q;
   logic [15:0] err_cnt_q;
   logic [1:0]  gnt;
   logic [31:0] resp_data;

   // grants only happen in IDLE, and never while reset is held
   rr_arb2 u_rr (
      .req0 (req0),
      .req1 (req1),
      .ptr  (last_q),
      .en   ((state_q == ARB_IDLE) && reset_n),
      .gnt  (gnt)
   );

   assign gnt0      = gnt[0];
   assign gnt1      = gnt[1];
   assign err_count = err_cnt_q;
   assign resp_data = (!pay_q.we && !inv_cap_q) ? rdata_cap_q : 32'h0;

   // FSM state register; async reset also kills an in-flight write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state, memory drive in ISSUE, response pulse in RESP
   always_comb begin
      state_d  = state_q;
      dm_addr  = 32'h0;
      dm_wdata = 32'h0;
      dm_we    = 1'b0;
      dm_mode  = DM_NONE;
      rvalid0  = 1'b0;
      rvalid1  = 1'b0;
      rdata0   = 32'h0;
      rdata1   = 32'h0;
      err0     = 1'b0;
      err1     = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (|gnt) state_d = ARB_ISSUE;
         end
         ARB_ISSUE: begin
            state_d  = ARB_RESP;
            dm_addr  = pay_q.addr;
            dm_wdata = pay_q.wdata;
            dm_we    = pay_q.we ? DM_WRITE_ENABLED : ~DM_WRITE_ENABLED;
            dm_mode  = pay_q.mode;
         end
         ARB_RESP: begin
            state_d = ARB_IDLE;
            if (sel_q) begin
               rvalid1 = 1'b1;
               rdata1  = resp_data;
               err1    = inv_cap_q;
            end else begin
               rvalid0 = 1'b1;
               rdata0  = resp_data;
               err0    = inv_cap_q;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // payload latch on grant, memory result capture, saturating error count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q      <= 1'b1;
         sel_q       <= 1'b0;
         pay_q       <= '{we: 1'b0, addr: 32'h0, wdata: 32'h0, mode: DM_NONE};
         rdata_cap_q <= 32'h0;
         inv_cap_q   <= 1'b0;
         err_cnt_q   <= 16'h0;
      end else begin
         if (|gnt) begin
            sel_q  <= gnt[1];
            last_q <= gnt[1];
            if (gnt[1]) begin
               pay_q <= '{we: we1, addr: addr1, wdata: wdata1, mode: mode1};
            end else begin
               pay_q <= '{we: we0, addr: addr0, wdata: wdata0, mode: mode0};
            end
         end
         if (state_q == ARB_ISSUE) begin
            rdata_cap_q <= dm_rdata;
            inv_cap_q   <= dm_invalid;
         end
         if ((state_q == ARB_RESP) && inv_cap_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_dm_arb.sv
// tb/tb_dm_arb.sv - randomized and directed check of dm_arb against a transaction model
module tb_dm_arb;
   import dm_arb_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic [2:0]  mode0, mode1;
   logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_we, dm_invalid;
   logic [2:0]  dm_mode;
   logic [15:0] err_count;

   dm_arb dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .mode0(mode0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .mode1(mode1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_mode(dm_mode),
      .dm_rdata(dm_rdata), .dm_invalid(dm_invalid), .err_count(err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- data memory (environment) and reference copy ----------------
   logic [7:0] env_mem [256];
   logic [7:0] ref_mem [256];

   function automatic logic acc_ok(logic [31:0] a, logic [2:0] m);
      if (a[31:8] != 24'h0) return 1'b0;
      case (m)
         DM_W:        return a[1:0] == 2'b00;
         DM_H, DM_HU: return a[0] == 1'b0;
         DM_B, DM_BU: return 1'b1;
         default:     return 1'b0;
      endcase
   endfunction

   function automatic int nbytes(logic [2:0] m);
      case (m)
         DM_W:        return 4;
         DM_H, DM_HU: return 2;
         default:     return 1;
      endcase
   endfunction

   function automatic logic [31:0] extend(logic [31:0] raw, logic [2:0] m);
      case (m)
         DM_W:    return raw;
         DM_H:    return {{16{raw[15]}}, raw[15:0]};
         DM_HU:   return {16'h0, raw[15:0]};
         DM_B:    return {{24{raw[7]}}, raw[7:0]};
         default: return {24'h0, raw[7:0]};
      endcase
   endfunction

   logic [7:0]  env_i0, env_i1, env_i2, env_i3;
   logic [31:0] env_raw;

   always_comb begin
      env_i0     = dm_addr[7:0];
      env_i1     = env_i0 + 8'd1;
      env_i2     = env_i0 + 8'd2;
      env_i3     = env_i0 + 8'd3;
      env_raw    = {env_mem[env_i3], env_mem[env_i2], env_mem[env_i1], env_mem[env_i0]};
      dm_invalid = !acc_ok(dm_addr, dm_mode);
      dm_rdata   = dm_invalid ? 32'hBAD0_BAD0 : extend(env_raw, dm_mode);
   end

   always @(posedge clk) begin
      if (dm_we && !dm_invalid) begin
         for (int k = 0; k < nbytes(dm_mode); k++) begin
            env_mem[dm_addr[7:0] + 8'(k)] <= dm_wdata[8*k +: 8];
         end
      end
   end

   function automatic logic [31:0] ref_read(logic [31:0] a, logic [2:0] m);
      logic [7:0] i;
      i = a[7:0];
      return extend({ref_mem[i + 8'd3], ref_mem[i + 8'd2], ref_mem[i + 8'd1], ref_mem[i]}, m);
   endfunction

   task automatic ref_write(logic [31:0] a, logic [31:0] d, logic [2:0] m);
      for (int k = 0; k < nbytes(m); k++) ref_mem[a[7:0] + 8'(k)] = d[8*k +: 8];
   endtask

   // ---------------- requester drive variables ----------------
   logic        r_v  [2];
   logic        we_v [2];
   logic [31:0] a_v  [2];
   logic [31:0] d_v  [2];
   logic [2:0]  m_v  [2];

   // ---------------- transaction-level model ----------------
   // phase: 0 free slot, 1 memory access cycle, 2 response cycle
   int          phase;
   int          last;
   int          sport;
   logic        s_we;
   logic [31:0] s_addr, s_wdata;
   logic [2:0]  s_mode;
   logic [31:0] x_rdata;
   logic        x_err;
   logic [15:0] x_cnt;
   bit          granted [2];
   int          glog [$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      phase = 0;
      last  = 1;
      x_cnt = 16'h0;
      granted[0] = 1'b0;
      granted[1] = 1'b0;
   endtask

   task automatic clear_reqs();
      for (int p = 0; p < 2; p++) begin
         r_v[p] = 1'b0; we_v[p] = 1'b0; a_v[p] = 32'h0; d_v[p] = 32'h0; m_v[p] = DM_NONE;
      end
   endtask

   task automatic set_req(int p, logic w, logic [31:0] a, logic [31:0] d, logic [2:0] m);
      r_v[p] = 1'b1; we_v[p] = w; a_v[p] = a; d_v[p] = d; m_v[p] = m;
   endtask

   task automatic apply_inputs();
      req0 = r_v[0]; we0 = we_v[0]; addr0 = a_v[0]; wdata0 = d_v[0]; mode0 = m_v[0];
      req1 = r_v[1]; we1 = we_v[1]; addr1 = a_v[1]; wdata1 = d_v[1]; mode1 = m_v[1];
   endtask

   // one clock: drive inputs, compare every output against the model, advance the model
   task automatic tick();
      logic [1:0]  eg, erv;
      logic [31:0] ea, ed, er0, er1;
      logic        ewe, ee0, ee1;
      logic [2:0]  em;
      int          win;
      @(negedge clk);
      apply_inputs();
      #1;
      eg = 2'b00; erv = 2'b00; ea = 32'h0; ed = 32'h0; ewe = 1'b0; em = DM_NONE;
      er0 = 32'h0; er1 = 32'h0; ee0 = 1'b0; ee1 = 1'b0; win = -1;
      if (phase == 0) begin
         if (r_v[0] && r_v[1]) win = (last == 1) ? 0 : 1;
         else if (r_v[0])      win = 0;
         else if (r_v[1])      win = 1;
         if (win >= 0) eg[win] = 1'b1;
      end else if (phase == 1) begin
         ea = s_addr; ed = s_wdata; ewe = s_we; em = s_mode;
      end else begin
         erv[sport] = 1'b1;
         if (sport == 0) begin er0 = x_rdata; ee0 = x_err; end
         else            begin er1 = x_rdata; ee1 = x_err; end
      end
      chk("gnt0", gnt0, eg[0]);
      chk("gnt1", gnt1, eg[1]);
      chk("rvalid0", rvalid0, erv[0]);
      chk("rvalid1", rvalid1, erv[1]);
      chk("rdata0", rdata0, er0);
      chk("rdata1", rdata1, er1);
      chk("err0", err0, ee0);
      chk("err1", err1, ee1);
      chk("dm_addr", dm_addr, ea);
      chk("dm_wdata", dm_wdata, ed);
      chk("dm_we", dm_we, ewe);
      chk("dm_mode", dm_mode, em);
      chk("err_count", err_count, x_cnt);
      if (gnt0) glog.push_back(0);
      if (gnt1) glog.push_back(1);
      case (phase)
         0: if (win >= 0) begin
               sport = win; last = win; granted[win] = 1'b1;
               s_we = we_v[win]; s_addr = a_v[win]; s_wdata = d_v[win]; s_mode = m_v[win];
               phase = 1;
            end
         1: begin
               x_err   = !acc_ok(s_addr, s_mode);
               x_rdata = (!s_we && !x_err) ? ref_read(s_addr, s_mode) : 32'h0;
               if (s_we && !x_err) ref_write(s_addr, s_wdata, s_mode);
               phase = 2;
            end
         default: begin
               if (x_err && x_cnt != 16'hFFFF) x_cnt = x_cnt + 16'd1;
               phase = 0;
            end
      endcase
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_reqs();
      apply_inputs();
      req0 = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_gnt0", gnt0, 1'b0);
      chk("rst_gnt1", gnt1, 1'b0);
      chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
      chk("rst_err", {err1, err0}, 2'b00);
      chk("rst_rdata0", rdata0, 32'h0);
      chk("rst_rdata1", rdata1, 32'h0);
      chk("rst_err_count", err_count, 16'h0);
      chk("rst_dm_we", dm_we, 1'b0);
      chk("rst_dm_mode", dm_mode, DM_NONE);
      req0 = 1'b0;
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic rand_payload(int p);
      logic [31:0] a;
      a = ($urandom % 2 == 0) ? {24'h0, 6'($urandom_range(0, 63)), 2'b00} : 32'($urandom_range(0, 255));
      if ($urandom % 16 == 0) a = a | 32'h0000_1000;
      set_req(p, 1'($urandom % 2), a, $urandom, 3'($urandom_range(0, 7)));
   endtask

   // requesters: hold until granted, sometimes withdraw before a grant
   task automatic rnd_drive();
      for (int p = 0; p < 2; p++) begin
         if (granted[p]) begin
            r_v[p] = 1'b0;
            granted[p] = 1'b0;
            if ($urandom % 3 == 0) rand_payload(p);
         end else if (r_v[p]) begin
            if ($urandom % 16 == 0) r_v[p] = 1'b0;
         end else if ($urandom % 3 == 0) begin
            rand_payload(p);
         end
      end
   endtask

   logic [31:0] word20;

   initial begin
      reset_n = 1'b0;
      clear_reqs();
      apply_inputs();
      for (int i = 0; i < 256; i++) begin
         env_mem[i] = 8'($urandom);
         ref_mem[i] = env_mem[i];
      end
      do_reset();

      // write 0x10 from port 0: gnt, then memory write, then response
      set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, DM_W);
      tick();
      chk("w_gnt0", gnt0, 1'b1);
      clear_reqs();
      tick();
      chk("w_dm_we", dm_we, 1'b1);
      tick();
      chk("w_rvalid0", rvalid0, 1'b1);
      chk("w_err0", err0, 1'b0);

      // byte-unsigned read of the just-written word from port 1
      set_req(1, 1'b0, 32'h10, 32'h0, DM_BU);
      tick();
      clear_reqs();
      tick();
      tick();
      chk("bu_rdata1", rdata1, 32'h0000_00EF);
      chk("bu_err1", err1, 1'b0);

      // misaligned word read is rejected
      set_req(0, 1'b0, 32'h11, 32'h0, DM_W);
      tick();
      clear_reqs();
      tick();
      tick();
      chk("mis_err0", err0, 1'b1);
      chk("mis_rdata0", rdata0, 32'h0);
      tick();
      chk("mis_err_count", err_count, 16'd1);

      // both ports held from reset alternate 0,1,0,1
      do_reset();
      glog.delete();
      set_req(0, 1'b0, 32'h40, 32'h0, DM_W);
      set_req(1, 1'b0, 32'h44, 32'h0, DM_W);
      repeat (12) tick();
      clear_reqs();
      chk("rr_grants", glog.size(), 4);
      for (int i = 0; i < glog.size(); i++) chk("rr_order", glog[i], i % 2);

      // reset during the memory cycle of a write to 0x20
      word20 = {env_mem[8'h23], env_mem[8'h22], env_mem[8'h21], env_mem[8'h20]};
      set_req(0, 1'b1, 32'h20, 32'h1234_5678, DM_W);
      tick();
      chk("rst_wr_gnt0", gnt0, 1'b1);
      clear_reqs();
      @(negedge clk);
      apply_inputs();
      #1;
      chk("rst_wr_issue_we", dm_we, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("rst_wr_we_cleared", dm_we, 1'b0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) tick();
      chk("rst_wr_word", {env_mem[8'h23], env_mem[8'h22], env_mem[8'h21], env_mem[8'h20]}, word20);
      set_req(0, 1'b0, 32'h20, 32'h0, DM_W);
      tick();
      chk("rst_wr_idle_gnt0", gnt0, 1'b1);
      clear_reqs();
      tick();
      tick();
      chk("rst_wr_read_back", rdata0, word20);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rnd_drive();
         tick();
      end
      clear_reqs();
      repeat (3) tick();

      // saturation of the error counter, starting just below the top
      @(negedge clk);
      force dut.err_cnt_q = 16'hFFC0;
      @(negedge clk);
      release dut.err_cnt_q;
      x_cnt = 16'hFFC0;
      for (int i = 0; i < 80; i++) begin
         set_req(i % 2, 1'b0, 32'h11, 32'h0, DM_W);
         tick();
         clear_reqs();
         tick();
         tick();
      end
      tick();
      chk("sat_err_count", err_count, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
